// File: rtl/mem_access_stage_if.sv
// Request/response bundle between the execute side and the SEQ memory stage.
interface mem_access_stage_if;
  logic        start;
  logic [3:0]  in_code;
  logic [63:0] val_e;
  logic [63:0] val_a;
  logic [63:0] val_p;
  logic        busy;
  logic        done;
  logic [63:0] val_m;
  logic [2:0]  stat;

  modport master (
    output start, in_code, val_e, val_a, val_p,
    input  busy, done, val_m, stat
  );

  modport slave (
    input  start, in_code, val_e, val_a, val_p,
    output busy, done, val_m, stat
  );
endinterface

// File: rtl/mem_access_stage.sv
// SEQ Y86-64 memory stage: owns a byte-addressed data memory and serialises
// each 8-byte load/store over 8/BYTES_PER_BEAT beats before reporting to
// writeback. Define MEM_ALIGN_CHECK_EN to reject memory ops whose address is
// not 8-byte aligned (stat=ADR); by default unaligned accesses are legal.
module mem_access_stage #(
  parameter int unsigned MEM_BYTES      = 1024,
  parameter int unsigned BYTES_PER_BEAT = 1
) (
  input logic               clock,
  input logic               reset,
  mem_access_stage_if.slave bus
);
  localparam int unsigned AW        = $clog2(MEM_BYTES);
  localparam int unsigned BEATS     = 8 / BYTES_PER_BEAT;
  localparam int unsigned CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [63:0] ADDR_MAX  = 64'(MEM_BYTES - 8);
  localparam logic [2:0]  ST_AOK    = 3'd1;
  localparam logic [2:0]  ST_HLT    = 3'd2;
  localparam logic [2:0]  ST_ADR    = 3'd3;
  localparam logic [2:0]  ST_INS    = 3'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   shadow_q, shadow_d;
  logic [63:0]   val_m_q, val_m_d;
  logic [2:0]    req_stat_q, req_stat_d;
  logic [2:0]    stat_q, stat_d;
  logic          is_wr_q, is_wr_d;
  logic          is_rd_q, is_rd_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    mem_q [MEM_BYTES];

  logic          req_wr_c, req_rd_c, req_bad_c, misalign_c;
  logic [63:0]   req_addr_c, req_data_c;
  logic [AW-1:0] beat_off_c, beat_addr_c;
  logic          wr_en_c;

  // Decode the incoming request: direction, address source and store data.
  always_comb begin
    req_wr_c   = 1'b0;
    req_rd_c   = 1'b0;
    req_addr_c = bus.val_e;
    req_data_c = bus.val_a;
    case (bus.in_code)
      4'd4, 4'd10: req_wr_c = 1'b1;
      4'd8: begin
        req_wr_c   = 1'b1;
        req_data_c = bus.val_p;
      end
      4'd5: req_rd_c = 1'b1;
      4'd9, 4'd11: begin
        req_rd_c   = 1'b1;
        req_addr_c = bus.val_a;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_c = (req_addr_c[2:0] != 3'd0);
`else
  assign misalign_c = 1'b0;
`endif

  assign req_bad_c   = (req_wr_c | req_rd_c) & ((req_addr_c > ADDR_MAX) | misalign_c);
  assign beat_off_c  = AW'(32'(beat_q) * BYTES_PER_BEAT);
  assign beat_addr_c = addr_q + beat_off_c;

  // Next-state and register-input logic for the request sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    shadow_d   = shadow_q;
    val_m_d    = val_m_q;
    req_stat_d = req_stat_q;
    stat_d     = stat_q;
    is_wr_d    = is_wr_q;
    is_rd_d    = is_rd_q;
    beat_d     = beat_q;
    done_d     = 1'b0;
    wr_en_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !busy_q) begin
          addr_d   = req_addr_c[AW-1:0];
          data_d   = req_data_c;
          shadow_d = '0;
          beat_d   = '0;
          is_wr_d  = req_wr_c & ~req_bad_c;
          is_rd_d  = req_rd_c & ~req_bad_c;
          if (bus.in_code == 4'd0)       req_stat_d = ST_HLT;
          else if (bus.in_code > 4'd11)  req_stat_d = ST_INS;
          else if (req_bad_c)            req_stat_d = ST_ADR;
          else                           req_stat_d = ST_AOK;
          state_d = ((req_wr_c | req_rd_c) && !req_bad_c) ? ACCESS : FINISH;
        end
      end
      ACCESS: begin
        wr_en_c = is_wr_q;
        if (is_rd_q) begin
          for (int unsigned j = 0; j < BYTES_PER_BEAT; j++) begin
            shadow_d[8*(32'(beat_q)*BYTES_PER_BEAT + j) +: 8] = mem_q[beat_addr_c + AW'(j)];
          end
        end
        beat_d = beat_q + CW'(1);
        if (beat_q == CW'(BEATS - 1)) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        stat_d  = req_stat_q;
        val_m_d = is_rd_q ? shadow_q : 64'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) | done_d;
  end

  // State and output registers; reset abandons any in-flight request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      shadow_q   <= '0;
      val_m_q    <= '0;
      req_stat_q <= ST_AOK;
      stat_q     <= ST_AOK;
      is_wr_q    <= 1'b0;
      is_rd_q    <= 1'b0;
      beat_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      shadow_q   <= shadow_d;
      val_m_q    <= val_m_d;
      req_stat_q <= req_stat_d;
      stat_q     <= stat_d;
      is_wr_q    <= is_wr_d;
      is_rd_q    <= is_rd_d;
      beat_q     <= beat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Data memory: one store beat committed per clock, contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en_c) begin
      for (int unsigned j = 0; j < BYTES_PER_BEAT; j++) begin
        mem_q[beat_addr_c + AW'(j)] <= data_q[8*(32'(beat_q)*BYTES_PER_BEAT + j) +: 8];
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.val_m = val_m_q;
  assign bus.stat  = stat_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed scenarios plus random ops,
// checked against a byte-array reference model of the memory stage.
module tb_mem_access_stage;
  localparam int unsigned MEM_BYTES      = 1024;
  localparam int unsigned BYTES_PER_BEAT = 1;

  typedef struct {
    logic [63:0] vm;
    logic [2:0]  st;
    int          lat;
    int          t0;
  } exp_t;

  logic clock;
  logic reset;
  mem_access_stage_if bus();

  mem_access_stage #(.MEM_BYTES(MEM_BYTES), .BYTES_PER_BEAT(BYTES_PER_BEAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mdl [MEM_BYTES];
  exp_t       sb_q[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural effect of one request, from the icode rules.
  task automatic model(input logic [3:0] code, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, output exp_t x);
    bit          wr, rd, bad;
    logic [63:0] addr, data;
    wr   = (code == 4) || (code == 10) || (code == 8);
    rd   = (code == 5) || (code == 9) || (code == 11);
    addr = (code == 9 || code == 11) ? a : e;
    data = (code == 8) ? p : a;
    x.vm  = 64'd0;
    x.lat = 2;
    x.t0  = cyc;
    if (code == 0)       x.st = 3'd2;
    else if (code > 11)  x.st = 3'd4;
    else                 x.st = 3'd1;
    if (wr || rd) begin
      bad = addr > 64'(MEM_BYTES - 8);
`ifdef MEM_ALIGN_CHECK_EN
      if (addr % 8 != 0) bad = 1'b1;
`endif
      if (bad) x.st = 3'd3;
      else begin
        x.lat = 8 / BYTES_PER_BEAT + 2;
        for (int i = 0; i < 8; i++) begin
          if (wr) mdl[int'(addr) + i] = data[8*i +: 8];
          else    x.vm[8*i +: 8] = mdl[int'(addr) + i];
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy === 1'b1) chk("busy_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic issue(input logic [3:0] code, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    exp_t x;
    wait_idle();
    bus.start   = 1'b1;
    bus.in_code = code;
    bus.val_e   = e;
    bus.val_a   = a;
    bus.val_p   = p;
    model(code, e, a, p, x);
    sb_q.push_back(x);
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Monitor: every done pops one expected response.
  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1 && bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          x = sb_q.pop_front();
          chk("val_m", bus.val_m, x.vm);
          chk("stat", 64'(bus.stat), 64'(x.st));
          chk("latency", 64'(cyc - x.t0), 64'(x.lat));
        end
      end
    end
  end

  initial begin
    logic [63:0] r;
    bus.start   = 1'b0;
    bus.in_code = 4'd0;
    bus.val_e   = 64'd0;
    bus.val_a   = 64'd0;
    bus.val_p   = 64'd0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_val_m", bus.val_m, 64'd0);
    chk("rst_stat", 64'(bus.stat), 64'd1);
    reset = 1'b0;
    @(negedge clock);

    // Fill memory so every later read sees defined data.
    for (int w = 0; w < int'(MEM_BYTES / 8); w++) begin
      r = {$urandom, $urandom};
      issue(4'd4, 64'(w * 8), r, 64'd0);
    end

    issue(4'd4, 64'h10, 64'h1122334455667788, 64'd0);
    issue(4'd5, 64'h10, 64'd0, 64'd0);
    issue(4'd8, 64'h3F8, 64'd0, 64'hABCD);
    issue(4'd9, 64'd0, 64'h3F8, 64'd0);
    issue(4'd4, 64'h3F9, 64'hDEAD, 64'd0);
    issue(4'd11, 64'd0, 64'h3F8, 64'd0);
    issue(4'd0, 64'd0, 64'd0, 64'd0);
    issue(4'hC, 64'd0, 64'd0, 64'd0);
    issue(4'd5, 64'h14, 64'd0, 64'd0);
    issue(4'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0);

    // Start pulse mid-load must be ignored.
    issue(4'd5, 64'h10, 64'd0, 64'd0);
    repeat (2) @(negedge clock);
    bus.start   = 1'b1;
    bus.in_code = 4'd0;
    @(negedge clock);
    bus.start = 1'b0;
    chk("busy_during_load", 64'(bus.busy), 64'd1);

    // Reset after four store beats over a zeroed word.
    issue(4'd4, 64'h40, 64'd0, 64'd0);
    wait_idle();
    bus.start   = 1'b1;
    bus.in_code = 4'd4;
    bus.val_e   = 64'h40;
    bus.val_a   = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) mdl[64 + i] = 8'hFF;
    @(negedge clock);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_stat", 64'(bus.stat), 64'd1);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    issue(4'd5, 64'h40, 64'd0, 64'd0);

    // Random traffic.
    for (int k = 0; k < 80; k++) begin
      logic [3:0]  c;
      logic [63:0] e, a;
      c = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MEM_BYTES - 1));
      a = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MEM_BYTES - 1));
      issue(c, e, a, {$urandom, $urandom});
    end

    wait_idle();
    repeat (4) @(negedge clock);
    if (sb_q.size() != 0) chk("missing_done", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
